// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: mask-logical opcodes, mask sequencer states and ALU control decode.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_NUM_ELEMENTS_REG = 128;

  typedef logic [RISCV_V_NUM_ELEMENTS_REG-1:0] riscv_v_mask_t;

  typedef enum logic [2:0] {
    MAND  = 3'd0,
    MNAND = 3'd1,
    MANDN = 3'd2,
    MXOR  = 3'd3,
    MOR   = 3'd4,
    MNOR  = 3'd5,
    MORN  = 3'd6,
    MXNOR = 3'd7
  } riscv_v_mask_op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SRC    = 3'd1,
    RD_VD     = 3'd2,
    EXEC      = 3'd3,
    WB        = 3'd4,
    DONE_SKIP = 3'd5
  } riscv_v_mask_ctrl_state_e;

  typedef struct packed {
    logic is_and;
    logic is_or;
    logic is_xor;
    logic negate_srca;
    logic negate_result;
  } riscv_v_mask_alu_ctrl_t;

  // Opcode to mask ALU control word; srca is vs1, srcb is vs2.
  function automatic riscv_v_mask_alu_ctrl_t riscv_v_mask_decode(input riscv_v_mask_op_e op);
    riscv_v_mask_alu_ctrl_t c;
    c = '0;
    case (op)
      MAND:    c.is_and = 1'b1;
      MNAND:   begin c.is_and = 1'b1; c.negate_result = 1'b1; end
      MANDN:   begin c.is_and = 1'b1; c.negate_srca   = 1'b1; end
      MXOR:    c.is_xor = 1'b1;
      MOR:     c.is_or  = 1'b1;
      MNOR:    begin c.is_or  = 1'b1; c.negate_result = 1'b1; end
      MORN:    begin c.is_or  = 1'b1; c.negate_srca   = 1'b1; end
      MXNOR:   begin c.is_xor = 1'b1; c.negate_result = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_v_mask_tail_gen.sv
// Body-mask generator: bit i is set when element i lies below the active vector length.
module riscv_v_mask_tail_gen
  import riscv_v_pkg::*;
#(
  parameter int unsigned NUM_ELEM = RISCV_V_NUM_ELEMENTS_REG,
  parameter int unsigned VL_W     = $clog2(NUM_ELEM) + 1
) (
  input  logic [VL_W-1:0]     vl,
  output logic [NUM_ELEM-1:0] body_mask_c
);

  always_comb begin
    body_mask_c = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      body_mask_c[i] = (i < 32'(vl));
    end
  end

endmodule

// File: rtl/riscv_v_mask_ctrl.sv
// Sequencer for vector mask-logical instructions: VRF read, mask ALU drive, vl tail merge, writeback.
// Define RISCV_V_MASK_TAIL_UNDISTURBED_EN to read old vd and keep tail bits; otherwise tail bits are written 1.
module riscv_v_mask_ctrl
  import riscv_v_pkg::*;
#(
  parameter int unsigned NUM_ELEM = RISCV_V_NUM_ELEMENTS_REG,
  parameter int unsigned VL_W     = $clog2(NUM_ELEM) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  riscv_v_mask_op_e    issue_op,
  input  logic [4:0]          issue_vd,
  input  logic [4:0]          issue_vs1,
  input  logic [4:0]          issue_vs2,
  input  logic [VL_W-1:0]     issue_vl,
  output logic                rd_req,
  output logic [4:0]          rd_addr_a,
  output logic [4:0]          rd_addr_b,
  input  logic                rd_valid,
  input  logic [NUM_ELEM-1:0] rd_data_a,
  input  logic [NUM_ELEM-1:0] rd_data_b,
  output logic                alu_is_mask,
  output logic                alu_is_and,
  output logic                alu_is_or,
  output logic                alu_is_xor,
  output logic                alu_negate_srca,
  output logic                alu_negate_result,
  output logic [NUM_ELEM-1:0] alu_srca,
  output logic [NUM_ELEM-1:0] alu_srcb,
  input  logic [NUM_ELEM-1:0] alu_result,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [4:0]          wb_addr,
  output logic [NUM_ELEM-1:0] wb_data,
  output logic                done
);

  localparam logic [VL_W-1:0] VL_MAX = VL_W'(NUM_ELEM);

  riscv_v_mask_ctrl_state_e state;
  riscv_v_mask_op_e         op_q;
  logic [VL_W-1:0]          vl_q;
  riscv_v_mask_alu_ctrl_t   dec;
  logic [NUM_ELEM-1:0]      body_mask;
  logic [NUM_ELEM-1:0]      tail_val;
  logic [NUM_ELEM-1:0]      merged;

`ifdef RISCV_V_MASK_TAIL_UNDISTURBED_EN
  logic [NUM_ELEM-1:0] src_a_q;
  logic [NUM_ELEM-1:0] src_b_q;
  logic [NUM_ELEM-1:0] old_vd_q;
  assign tail_val = old_vd_q;
`else
  assign tail_val = '1;
`endif

  riscv_v_mask_tail_gen #(
    .NUM_ELEM (NUM_ELEM),
    .VL_W     (VL_W)
  ) u_tail_gen (
    .vl          (vl_q),
    .body_mask_c (body_mask)
  );

  assign dec    = riscv_v_mask_decode(op_q);
  assign merged = (alu_result & body_mask) | (tail_val & ~body_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      issue_ready       <= 1'b1;
      op_q              <= MAND;
      vl_q              <= '0;
      rd_req            <= 1'b0;
      rd_addr_a         <= '0;
      rd_addr_b         <= '0;
      alu_is_mask       <= 1'b0;
      alu_is_and        <= 1'b0;
      alu_is_or         <= 1'b0;
      alu_is_xor        <= 1'b0;
      alu_negate_srca   <= 1'b0;
      alu_negate_result <= 1'b0;
      alu_srca          <= '0;
      alu_srcb          <= '0;
      wb_valid          <= 1'b0;
      wb_addr           <= '0;
      wb_data           <= '0;
      done              <= 1'b0;
`ifdef RISCV_V_MASK_TAIL_UNDISTURBED_EN
      src_a_q           <= '0;
      src_b_q           <= '0;
      old_vd_q          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid && issue_ready) begin
            op_q        <= issue_op;
            wb_addr     <= issue_vd;
            vl_q        <= (issue_vl > VL_MAX) ? VL_MAX : issue_vl;
            issue_ready <= 1'b0;
            if (issue_vl == '0) begin
              state <= DONE_SKIP;
              done  <= 1'b1;
            end else begin
              state     <= RD_SRC;
              rd_req    <= 1'b1;
              rd_addr_a <= issue_vs1;
              rd_addr_b <= issue_vs2;
            end
          end
        end
        RD_SRC: begin
          if (rd_valid) begin
`ifdef RISCV_V_MASK_TAIL_UNDISTURBED_EN
            src_a_q   <= rd_data_a;
            src_b_q   <= rd_data_b;
            rd_addr_a <= wb_addr;
            rd_addr_b <= wb_addr;
            state     <= RD_VD;
`else
            rd_req      <= 1'b0;
            alu_srca    <= rd_data_a;
            alu_srcb    <= rd_data_b;
            alu_is_mask <= 1'b1;
            {alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result} <= dec;
            state       <= EXEC;
`endif
          end
        end
`ifdef RISCV_V_MASK_TAIL_UNDISTURBED_EN
        RD_VD: begin
          if (rd_valid) begin
            old_vd_q    <= rd_data_a;
            rd_req      <= 1'b0;
            alu_srca    <= src_a_q;
            alu_srcb    <= src_b_q;
            alu_is_mask <= 1'b1;
            {alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result} <= dec;
            state       <= EXEC;
          end
        end
`endif
        // ALU output is valid this cycle; capture the tail-merged result and release the ALU.
        EXEC: begin
          wb_data     <= merged;
          wb_valid    <= 1'b1;
          alu_is_mask <= 1'b0;
          {alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result} <= 5'b0;
          alu_srca    <= '0;
          alu_srcb    <= '0;
          state       <= WB;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid    <= 1'b0;
            done        <= 1'b1;
            issue_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        DONE_SKIP: begin
          issue_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          issue_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_v_mask_ctrl.sv
// Scoreboard bench for riscv_v_mask_ctrl with a behavioural VRF, mask ALU and writeback sink.
module tb_riscv_v_mask_ctrl;
  import riscv_v_pkg::*;

`ifdef RISCV_V_MASK_TAIL_UNDISTURBED_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  riscv_v_mask_op_e issue_op;
  logic [4:0]       issue_vd, issue_vs1, issue_vs2;
  logic [4:0]       issue_vl;
  logic             rd_req;
  logic [4:0]       rd_addr_a, rd_addr_b;
  logic             rd_valid;
  logic [15:0]      rd_data_a, rd_data_b;
  logic             alu_is_mask, alu_is_and, alu_is_or, alu_is_xor;
  logic             alu_negate_srca, alu_negate_result;
  logic [15:0]      alu_srca, alu_srcb, alu_result;
  logic             wb_valid, wb_ready;
  logic [4:0]       wb_addr;
  logic [15:0]      wb_data;
  logic             done;

  riscv_v_mask_ctrl #(.NUM_ELEM(16), .VL_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vd(issue_vd), .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vl(issue_vl),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .alu_is_mask(alu_is_mask), .alu_is_and(alu_is_and), .alu_is_or(alu_is_or),
    .alu_is_xor(alu_is_xor), .alu_negate_srca(alu_negate_srca),
    .alu_negate_result(alu_negate_result),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_due = -1;
  int rd_delay = 0, wb_delay = 0;
  int rd_wait = 0, wb_wait = 0;
  logic [15:0] vrf [32];
  logic [20:0] exp_q [$];
  logic [9:0]  rd_log [$];
  logic [4:0]  exp_ctrl;
  logic [15:0] exp_srca, exp_srcb;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_addr;
  logic [15:0] prev_data;
  logic [15:0] alu_a, alu_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural mask ALU driven only by the DUT controls.
  always_comb begin
    alu_a = alu_negate_srca ? ~alu_srca : alu_srca;
    alu_r = '0;
    if (alu_is_and)      alu_r = alu_a & alu_srcb;
    else if (alu_is_or)  alu_r = alu_a | alu_srcb;
    else if (alu_is_xor) alu_r = alu_a ^ alu_srcb;
    if (alu_negate_result) alu_r = ~alu_r;
    alu_result = alu_is_mask ? alu_r : '0;
  end

  function automatic logic [15:0] ref_op(input riscv_v_mask_op_e op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      MAND:    return a & b;
      MNAND:   return ~(a & b);
      MANDN:   return b & ~a;
      MXOR:    return a ^ b;
      MOR:     return a | b;
      MNOR:    return ~(a | b);
      MORN:    return b | ~a;
      default: return ~(a ^ b);
    endcase
  endfunction

  function automatic logic [4:0] ref_ctrl(input riscv_v_mask_op_e op);
    case (op)
      MAND:    return 5'b10000;
      MNAND:   return 5'b10001;
      MANDN:   return 5'b10010;
      MXOR:    return 5'b00100;
      MOR:     return 5'b01000;
      MNOR:    return 5'b01001;
      MORN:    return 5'b01010;
      default: return 5'b00101;
    endcase
  endfunction

  function automatic logic [15:0] ref_wb(input riscv_v_mask_op_e op, input logic [4:0] vd,
                                         input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vl);
    logic [16:0] t;
    logic [15:0] body, tail;
    t    = (17'h1 << vl) - 17'h1;
    body = t[15:0];
    tail = (XL == 1) ? vrf[vd] : 16'hFFFF;
    return (ref_op(op, vrf[vs1], vrf[vs2]) & body) | (tail & ~body);
  endfunction

  // VRF read responder, writeback sink and output monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rd_req && !rst) begin
      if (rd_wait >= rd_delay) begin
        rd_valid = 1'b1; rd_data_a = vrf[rd_addr_a]; rd_data_b = vrf[rd_addr_b]; rd_wait = 0;
        rd_log.push_back({rd_addr_a, rd_addr_b});
      end else begin
        rd_valid = 1'b0; rd_wait++;
      end
    end else begin
      rd_valid = 1'b0; rd_wait = 0;
    end
    if (wb_valid && !rst) begin
      if (wb_wait >= wb_delay) begin wb_ready = 1'b1; wb_wait = 0; end
      else begin wb_ready = 1'b0; wb_wait++; end
    end else begin
      wb_ready = 1'b0; wb_wait = 0;
    end

    if (wb_valid && wb_ready) begin
      if (exp_q.size() == 0) check_eq("wb_unexpected", 1, 0);
      else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check_eq("wb_addr", 32'(wb_addr), 32'(e[20:16]));
        check_eq("wb_data", 32'(wb_data), 32'(e[15:0]));
      end
      done_due = cyc + 1;
    end
    if (prev_stall && wb_valid) begin
      check_eq("wb_addr_stable", 32'(wb_addr), 32'(prev_addr));
      check_eq("wb_data_stable", 32'(wb_data), 32'(prev_data));
    end
    prev_stall = wb_valid && !wb_ready;
    prev_addr  = wb_addr;
    prev_data  = wb_data;

    if (done || cyc == done_due) check_eq("done_pulse", 32'(done), 32'(cyc == done_due));

    if (alu_is_mask) begin
      check_eq("alu_ctrl", 32'({alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result}), 32'(exp_ctrl));
      check_eq("alu_srca", 32'(alu_srca), 32'(exp_srca));
      check_eq("alu_srcb", 32'(alu_srcb), 32'(exp_srcb));
    end else if ({alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result} != 5'b0 ||
                 alu_srca != 16'h0 || alu_srcb != 16'h0) begin
      check_eq("alu_idle", 1, 0);
    end
  end

  task automatic run_op(input riscv_v_mask_op_e op, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [4:0] vl, output int fire_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!issue_ready && n < 200) begin @(negedge clk); n++; end
    check_eq("issue_wait", 32'(n < 200), 1);
    issue_valid = 1'b1; issue_op = op; issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2; issue_vl = vl;
    fire_cyc = cyc;
    exp_ctrl = ref_ctrl(op);
    exp_srca = vrf[vs1];
    exp_srcb = vrf[vs2];
    if (vl != 5'd0) exp_q.push_back({vd, ref_wb(op, vd, vs1, vs2, vl)});
    else done_due = cyc + 1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !issue_ready || cyc <= done_due) && n < 300) begin
      @(negedge clk); n++;
    end
    check_eq("idle_wait", 32'(n < 300), 1);
  endtask

  initial begin
    int c, n, n_rd, n_wb;
    rst = 1'b1; issue_valid = 1'b0; issue_op = MAND;
    issue_vd = '0; issue_vs1 = '0; issue_vs2 = '0; issue_vl = '0;
    rd_valid = 1'b0; rd_data_a = '0; rd_data_b = '0; wb_ready = 1'b0;
    for (int i = 0; i < 32; i++) vrf[i] = 16'(i * 16'h1111);
    repeat (3) @(negedge clk);
    check_eq("rst_issue_ready", 32'(issue_ready), 1);
    check_eq("rst_rd_req", 32'(rd_req), 0);
    check_eq("rst_wb_valid", 32'(wb_valid), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_alu", 32'({alu_is_mask, alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result}), 0);
    check_eq("rst_addr", 32'({rd_addr_a, rd_addr_b, wb_addr}), 0);
    check_eq("rst_wb_data", 32'(wb_data), 0);
    rst = 1'b0;

    // MANDN with minimum latency
    vrf[1] = 16'h00FF; vrf[2] = 16'h0F0F;
    check_eq("ref_mandn", 32'(ref_wb(MANDN, 5'd3, 5'd1, 5'd2, 5'd16)), 32'h0F00);
    run_op(MANDN, 5'd3, 5'd1, 5'd2, 5'd16, c);
    @(negedge clk);
    check_eq("t1_rd_req", 32'(rd_req), 1);
    check_eq("t1_rd_addr", 32'({rd_addr_a, rd_addr_b}), 32'({5'd1, 5'd2}));
    check_eq("t1_busy", 32'(issue_ready), 0);
    repeat (1 + XL) @(negedge clk);
    check_eq("t1_exec", 32'(alu_is_mask), 1);
    @(negedge clk);
    check_eq("t1_wb_valid", 32'(wb_valid), 1);
    @(negedge clk);
    check_eq("t1_latency", 32'(cyc - c), 32'(4 + XL));
    check_eq("t1_ready_again", 32'(issue_ready), 1);
    wait_idle();

    // MNOR with partial vl; tail either ones or old vd
    vrf[4] = 16'h1234; vrf[5] = 16'h00F0; vrf[6] = 16'hA5A5;
    check_eq("ref_mnor", 32'(ref_wb(MNOR, 5'd6, 5'd4, 5'd5, 5'd8)), (XL == 1) ? 32'hA50B : 32'hFF0B);
    rd_log.delete();
    run_op(MNOR, 5'd6, 5'd4, 5'd5, 5'd8, c);
    wait_idle();
    check_eq("t2_rd_phases", 32'(rd_log.size()), 32'(1 + XL));
    if (rd_log.size() > 0) check_eq("t2_rd_src", 32'(rd_log[0]), 32'({5'd4, 5'd5}));
    if (rd_log.size() > 1) check_eq("t2_rd_vd", 32'(rd_log[1]), 32'({5'd6, 5'd6}));

    // MXNOR with vl beyond NUM_ELEM
    vrf[7] = 16'hAAAA; vrf[8] = 16'hFFFF;
    run_op(MXNOR, 5'd9, 5'd7, 5'd8, 5'd20, c);
    wait_idle();

    // vl == 0 skips the VRF entirely
    run_op(MXOR, 5'd10, 5'd1, 5'd2, 5'd0, c);
    @(negedge clk);
    check_eq("t4_no_rd", 32'(rd_req), 0);
    check_eq("t4_no_wb", 32'(wb_valid), 0);
    check_eq("t4_busy", 32'(issue_ready), 0);
    @(negedge clk);
    check_eq("t4_ready", 32'(issue_ready), 1);
    check_eq("t4_no_rd2", 32'(rd_req), 0);
    wait_idle();

    // MOR with read and writeback stalls
    vrf[11] = 16'h000F; vrf[12] = 16'h00F0;
    rd_delay = 3; wb_delay = 4;
    run_op(MOR, 5'd13, 5'd11, 5'd12, 5'd16, c);
    n_rd = 0; n_wb = 0; n = 0;
    while (n < 80) begin
      @(negedge clk); n++;
      if (done) break;
      check_eq("t5_busy", 32'(issue_ready), 0);
      n_rd += int'(rd_req);
      n_wb += int'(wb_valid);
    end
    check_eq("t5_done_seen", 32'(n < 80), 1);
    check_eq("t5_rd_cycles", 32'(n_rd), 32'(4 * (1 + XL)));
    check_eq("t5_wb_cycles", 32'(n_wb), 5);
    rd_delay = 0; wb_delay = 0;
    wait_idle();

    // Reset while a writeback is pending
    vrf[14] = 16'h3C3C; vrf[15] = 16'h0FF0;
    wb_delay = 100;
    run_op(MXOR, 5'd16, 5'd14, 5'd15, 5'd16, c);
    n = 0;
    while (!wb_valid && n < 50) begin @(negedge clk); n++; end
    check_eq("t6_wb_reached", 32'(wb_valid), 1);
    @(negedge clk);
    rst = 1'b1; exp_q.delete(); done_due = -1;
    @(negedge clk);
    check_eq("t6_wb_dropped", 32'(wb_valid), 0);
    check_eq("t6_idle", 32'(issue_ready), 1);
    check_eq("t6_no_rd", 32'(rd_req), 0);
    rst = 1'b0; wb_delay = 0;
    repeat (5) begin
      @(negedge clk);
      check_eq("t6_no_done", 32'(done), 0);
    end
    vrf[17] = 16'hF0F3; vrf[18] = 16'h0FFF; vrf[19] = 16'h1234;
    check_eq("ref_mand_vl5", 32'(ref_wb(MAND, 5'd19, 5'd17, 5'd18, 5'd5)), (XL == 1) ? 32'h1233 : 32'hFFF3);
    run_op(MAND, 5'd19, 5'd17, 5'd18, 5'd5, c);
    wait_idle();

    // Sweep all opcodes with random operands and lengths
    for (int i = 0; i < 8; i++) begin
      vrf[20] = 16'($urandom); vrf[21] = 16'($urandom); vrf[22] = 16'($urandom);
      run_op(riscv_v_mask_op_e'(i), 5'd22, 5'd20, 5'd21, 5'($urandom_range(1, 16)), c);
      wait_idle();
    end

    check_eq("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_v_mask_ctrl.md
# riscv_v_mask_ctrl

Sequencer for vector mask-logical instructions (vmand, vmnand, vmandn, vmxor, vmor, vmnor, vmorn, vmxnor). It accepts one instruction at a time from the vector issue stage and reads vs1/vs2 from the vector register file. It drives the combinational mask ALU's control and operand inputs, applies vl tail policy, and writes vd back through a valid/ready port. It sits between vector issue, VRF read/write ports and the mask ALU instance.

## Interface
- NUM_ELEM, default RISCV_V_NUM_ELEMENTS_REG: mask bits per vector register.
- VL_W, default $clog2(NUM_ELEM)+1: vl width.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  controller idle, can accept
- issue_op  in  riscv_v_mask_op_e  mask operation
- issue_vd / issue_vs1 / issue_vs2  in  5 each  register indices
- issue_vl  in  VL_W  active vector length
- rd_req  out  1  VRF read request
- rd_addr_a / rd_addr_b  out  5 each  VRF read addresses
- rd_valid  in  1  read data valid
- rd_data_a / rd_data_b  in  NUM_ELEM each  read data
- alu_is_mask, alu_is_and, alu_is_or, alu_is_xor, alu_negate_srca, alu_negate_result  out  1 each  mask ALU controls
- alu_srca / alu_srcb  out  NUM_ELEM each  ALU operands (vs1 / vs2)
- alu_result  in  NUM_ELEM  ALU output
- wb_valid  out  1  writeback offered
- wb_ready  in  1  VRF accepts writeback
- wb_addr  out  5  vd
- wb_data  out  NUM_ELEM  final vd value
- done  out  1  one-cycle completion pulse

## Operation
- Handshake:
  - Issue fires on issue_valid && issue_ready.
  - issue_ready = (state == IDLE).
  - op, vd, vs1, vs2 and vl are captured on fire.
- vl > NUM_ELEM is clamped to NUM_ELEM at capture.
- States:
  - IDLE: fire with vl==0 → DONE_SKIP; fire with vl>0 → RD_SRC.
  - RD_SRC: rd_req=1, rd_addr_a=vs1, rd_addr_b=vs2, held until rd_valid. On rd_valid, capture both operands; go to RD_VD if macro enabled, else EXEC.
  - RD_VD (macro only): rd_req=1, rd_addr_a=vd, rd_addr_b=vd. On rd_valid, capture rd_data_a as old_vd; go to EXEC.
  - EXEC: one cycle. ALU controls asserted, ALU inputs driven from captured operands, final result registered; go to WB.
  - WB: wb_valid=1. On wb_ready → IDLE, with done=1 in the following cycle.
  - DONE_SKIP: done=1 for one cycle → IDLE. No VRF read or write.
- rd_valid may arrive in the same cycle rd_req first asserts. It is ignored outside RD_SRC/RD_VD.
- Op decode (srca=vs1, srcb=vs2; is_mask=1 in EXEC only):
  - MAND: and
  - MNAND: and + negate_result
  - MANDN: and + negate_srca
  - MXOR: xor
  - MOR: or
  - MNOR: or + negate_result
  - MORN: or + negate_srca
  - MXNOR: xor + negate_result
- Outside EXEC, all alu_* controls are 0 and alu_srca/alu_srcb are 0, so the ALU output is 0.
- Result merge per bit i:
  - i < vl: alu_result[i].
  - i ≥ vl: tail value (see Configuration).
- wb_addr/wb_data are stable while wb_valid && !wb_ready.

## Timing
- Reset values:
  - state IDLE, so issue_ready=1.
  - rd_req, wb_valid, done and all alu_* outputs 0.
  - rd_addr_*, wb_addr and wb_data 0.
- Minimum latency, no macro, rd_valid same cycle, wb_ready=1:
  - fire cycle T → rd_req T+1 → EXEC T+2 → wb_valid T+3 → done T+4, issue_ready again at T+4.
  - Minimum issue interval: 4 cycles.
- Macro enabled: +1 cycle minimum. Each rd_valid or wb_ready stall adds one cycle per cycle stalled.
- vl==0: done at T+1, issue_ready at T+2.
- Reset mid-instruction: abandon immediately. No further rd_req, wb_valid or done.

## Configuration
- RISCV_V_MASK_TAIL_UNDISTURBED_EN:
  - Defined: RD_VD state exists; tail bits i ≥ vl take old_vd[i].
  - Undefined: RD_VD is absent; tail bits are written 1 (agnostic).

## Structure
- riscv_v_pkg holds:
  - riscv_v_mask_op_e, 3 bits: MAND=0, MNAND=1, MANDN=2, MXOR=3, MOR=4, MNOR=5, MORN=6, MXNOR=7.
  - riscv_v_mask_ctrl_state_e.
  - Existing riscv_v_mask_t and RISCV_V_NUM_ELEMENTS_REG.
- Sub-module riscv_v_mask_tail_gen: combinational vl → body mask, bit i = (i < vl). Used by the merge.

## Test plan
Bench runs with NUM_ELEM=16.
- MANDN, vs1=0x00FF, vs2=0x0F0F, vl=16 → ALU controls and+negate_srca in EXEC; wb_data=0x0F00; done one cycle after the wb handshake.
- MNOR, vs1=0x1234, vs2=0x00F0, vl=8:
  - Macro off → wb_data=0xFF0B.
  - Macro on with old vd=0xA5A5 → wb_data=0xA50B; two rd_req phases, vs1/vs2 then vd.
- MXNOR, vs1=0xAAAA, vs2=0xFFFF, vl=20 → vl clamped to 16; wb_data=0xAAAA.
- vl=0, any op → no rd_req, no wb_valid; done at T+1; issue_ready high again at T+2.
- rd_valid delayed 3 cycles and wb_ready low 4 cycles on MOR (vs1=0x000F, vs2=0x00F0, vl=16):
  - rd_req held until rd_valid.
  - wb_valid, wb_addr and wb_data=0x00FF held stable while wb_ready is low.
  - issue_ready low throughout.
- rst asserted during WB → next cycle: IDLE, wb_valid=0, done never pulses; a subsequent issue completes normally.
